// File: rtl/stb_sweep_pkg.sv
// Shared definitions for the strobe-delay sweep engine: FSM state encoding and
// default widths, also consumed by the SoC register map.
package stb_sweep_pkg;

    localparam int T_CNT_WIDTH_DEF = 32;
    localparam int HIT_WIDTH_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_STB = 3'd1,
        ST_DELAY    = 3'd2,
        ST_PUSH     = 3'd3,
        ST_DONE     = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/stb_delay_cnt.sv
// Loadable down-counter: a load of value v produces a one-cycle expiry pulse
// v+1 cycles after the load cycle (v=0 pulses in the very next cycle).
module stb_delay_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;
    logic             run_q;

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            expire_o <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= load_val_i;
            run_q    <= (load_val_i != '0);
            expire_o <= (load_val_i == '0);
        end else if (run_q) begin
            cnt_q    <= cnt_q - 1'b1;
            expire_o <= (cnt_q == WIDTH'(1));
            run_q    <= (cnt_q != WIDTH'(1));
        end else begin
            expire_o <= 1'b0;
        end
    end

endmodule

// File: rtl/stb_sweep.sv
// Sweeps a sampling offset across one strobe period, counting comparator hits
// at each offset over N strobes and handing each point out on a valid/ready port.
module stb_sweep
    import stb_sweep_pkg::*;
#(
    parameter int T_CNT_WIDTH = T_CNT_WIDTH_DEF,
    parameter int HIT_WIDTH   = HIT_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stb_i,
    input  logic                   stb_valid_i,
    input  logic [T_CNT_WIDTH-1:0] stb_period_i,
    input  logic                   sig_i,
    input  logic                   start_i,
    input  logic [T_CNT_WIDTH-1:0] step_i,
    input  logic [HIT_WIDTH-1:0]   avg_n_i,
    output logic                   dstb_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [T_CNT_WIDTH-1:0] res_offset_o,
    output logic [HIT_WIDTH-1:0]   res_hits_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    sweep_state_t           state_q;
    logic [T_CNT_WIDTH-1:0] period_q;
    logic [T_CNT_WIDTH-1:0] step_q;
    logic [T_CNT_WIDTH-1:0] offset_q;
    logic [HIT_WIDTH-1:0]   avg_n_q;
    logic [HIT_WIDTH-1:0]   hits_q;
    logic [HIT_WIDTH-1:0]   cnt_q;

    logic                   start_ok;
    logic                   active;
    logic                   dly_load;
    logic                   dly_clr;
    logic                   dly_exp;
    logic [T_CNT_WIDTH:0]   next_off;
    logic [HIT_WIDTH-1:0]   cnt_nxt;

    // One extra bit so offset+step cannot wrap below the period.
    assign next_off = {1'b0, offset_q} + {1'b0, step_q};
    assign cnt_nxt  = cnt_q + 1'b1;

    assign start_ok = stb_valid_i && (stb_period_i != '0) && (step_i != '0)
                      && (avg_n_i != '0);
    assign active   = (state_q == ST_WAIT_STB) || (state_q == ST_DELAY)
                      || (state_q == ST_PUSH);
    assign dly_load = (state_q == ST_WAIT_STB) && stb_valid_i && stb_i;
    assign dly_clr  = active && !stb_valid_i;

    stb_delay_cnt #(
        .WIDTH (T_CNT_WIDTH)
    ) u_delay (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (dly_clr),
        .load_i     (dly_load),
        .load_val_i (offset_q),
        .expire_o   (dly_exp)
    );

    assign dstb_o       = dly_exp;
    assign res_offset_o = offset_q;
    assign res_hits_o   = hits_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            step_q      <= '0;
            offset_q    <= '0;
            avg_n_q     <= '0;
            hits_q      <= '0;
            cnt_q       <= '0;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (dly_clr) begin
                // Strobe generator lost lock: abandon the sweep without done.
                state_q     <= ST_IDLE;
                res_valid_o <= 1'b0;
                busy_o      <= 1'b0;
                err_o       <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            if (start_ok) begin
                                period_q <= stb_period_i;
                                step_q   <= step_i;
                                avg_n_q  <= avg_n_i;
                                offset_q <= '0;
                                hits_q   <= '0;
                                cnt_q    <= '0;
                                err_o    <= 1'b0;
                                busy_o   <= 1'b1;
                                state_q  <= ST_WAIT_STB;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_STB: begin
                        if (stb_i) begin
                            state_q <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (dly_exp) begin
                            hits_q <= hits_q + HIT_WIDTH'(sig_i);
                            cnt_q  <= cnt_nxt;
                            if (cnt_nxt == avg_n_q) begin
                                res_valid_o <= 1'b1;
                                state_q     <= ST_PUSH;
                            end else begin
                                state_q <= ST_WAIT_STB;
                            end
                        end
                    end
                    ST_PUSH: begin
                        if (res_ready_i) begin
                            res_valid_o <= 1'b0;
                            if (next_off >= {1'b0, period_q}) begin
                                done_o  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                offset_q <= next_off[T_CNT_WIDTH-1:0];
                                hits_q   <= '0;
                                cnt_q    <= '0;
                                state_q  <= ST_WAIT_STB;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy_o  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stb_sweep.sv
// Self-checking bench for stb_sweep: directed scenarios plus randomized sweeps
// scored against a list of expected (offset, hits) points built from the rules.
module tb_stb_sweep;

    localparam int TW = 32;
    localparam int HW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          stb_i;
    logic          stb_valid_i;
    logic [TW-1:0] stb_period_i;
    logic          sig_i;
    logic          start_i;
    logic [TW-1:0] step_i;
    logic [HW-1:0] avg_n_i;
    logic          dstb_o;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [TW-1:0] res_offset_o;
    logic [HW-1:0] res_hits_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    stb_sweep #(
        .T_CNT_WIDTH (TW),
        .HIT_WIDTH   (HW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stb_i        (stb_i),
        .stb_valid_i  (stb_valid_i),
        .stb_period_i (stb_period_i),
        .sig_i        (sig_i),
        .start_i      (start_i),
        .step_i       (step_i),
        .avg_n_i      (avg_n_i),
        .dstb_o       (dstb_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_offset_o (res_offset_o),
        .res_hits_o   (res_hits_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_stb = 0;
    int tstb     = 22;
    bit auto_stb = 1'b0;
    bit man_stb  = 1'b0;
    bit pat [0:63];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; drive strobe and signal for that cycle.
    // sig_i follows pat[] indexed by cycles since the most recent strobe.
    task automatic step();
        int ph;
        @(negedge clk_i);
        cyc++;
        stb_i = auto_stb ? ((cyc - last_stb) >= tstb) : man_stb;
        if (stb_i) last_stb = cyc;
        ph = cyc - last_stb;
        if (ph > 63) ph = 63;
        sig_i = pat[ph];
    endtask

    task automatic do_reset();
        start_i = 1'b0;
        rst_i   = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic start_sweep(int unsigned p, int unsigned s, int unsigned n, bit v);
        stb_period_i = TW'(p);
        step_i       = TW'(s);
        avg_n_i      = HW'(n);
        stb_valid_i  = v;
        start_i      = 1'b1;
        step();
        start_i     = 1'b0;
        stb_valid_i = 1'b1;
    endtask

    // Full sweep with a free-running strobe slower than the period, random
    // backpressure and stray start pulses; optional 50-cycle stall on first point.
    task automatic run_sweep(int unsigned p, int unsigned s, int unsigned n, bit hold);
        int unsigned eo[$];
        int unsigned eh[$];
        int got = 0;
        int nd = 0;
        int hold_left;
        int exp_ph;
        bit done_seen = 1'b0;
        hold_left = hold ? 50 : 0;
        for (int unsigned o = 0; o < p; o += s) begin
            eo.push_back(o);
            eh.push_back(pat[o + 1] ? n : 0);
        end
        auto_stb    = 1'b1;
        tstb        = int'(p) + 2;
        res_ready_i = 1'b0;
        start_sweep(p, s, n, 1'b1);
        check("start_busy", busy_o, 1);
        check("start_err", err_o, 0);
        for (int k = 0; k < 30000 && !done_seen; k++) begin
            exp_ph = (eo.size() > 0) ? int'(eo[0]) + 1 : -1;
            if (dstb_o) begin
                check("dstb_phase", cyc - last_stb, exp_ph);
                nd++;
            end
            if (res_valid_o) begin
                if (eo.size() == 0) begin
                    check("extra_result", res_valid_o, 0);
                    res_ready_i = 1'b1;
                end else if (hold_left > 0) begin
                    check("hold_offset", res_offset_o, eo[0]);
                    check("hold_hits", res_hits_o, eh[0]);
                    check("hold_no_dstb", dstb_o, 0);
                    hold_left--;
                    res_ready_i = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    res_ready_i = 1'b1;
                    check("res_offset", res_offset_o, eo[0]);
                    check("res_hits", res_hits_o, eh[0]);
                    check("samples_per_point", nd, n);
                    void'(eo.pop_front());
                    void'(eh.pop_front());
                    got++;
                    nd = 0;
                end else begin
                    res_ready_i = 1'b0;
                end
            end else begin
                res_ready_i = 1'($urandom_range(0, 1));
            end
            if (done_o) begin
                done_seen = 1'b1;
                check("done_count", got, (p + s - 1) / s);
                check("done_busy", busy_o, 1);
            end
            start_i      = ($urandom_range(0, 15) == 0);
            stb_period_i = $urandom;
            step_i       = $urandom;
            step();
        end
        start_i = 1'b0;
        check("sweep_done_seen", done_seen, 1);
        check("done_one_cycle", done_o, 0);
        check("idle_busy", busy_o, 0);
        check("sweep_err", err_o, 0);
        check("idle_valid", res_valid_o, 0);
        res_ready_i = 1'b0;
        auto_stb    = 1'b0;
    endtask

    initial begin
        int t0;
        int dcount;
        int dcyc;
        int dn;
        int unsigned p;
        int unsigned s;
        int unsigned n;

        rst_i = 1'b1; stb_i = 1'b0; stb_valid_i = 1'b1; sig_i = 1'b0;
        start_i = 1'b0; res_ready_i = 1'b0; stb_period_i = '0; step_i = '0; avg_n_i = '0;
        foreach (pat[i]) pat[i] = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        step();
        check("rst_dstb", dstb_o, 0);
        check("rst_valid", res_valid_o, 0);
        check("rst_offset", res_offset_o, 0);
        check("rst_hits", res_hits_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);

        // Constant-high comparator: every point scores N.
        foreach (pat[i]) pat[i] = 1'b1;
        run_sweep(20, 5, 4, 1'b0);

        // Comparator high for 10 cycles after each strobe.
        foreach (pat[i]) pat[i] = (i <= 9);
        run_sweep(20, 6, 2, 1'b0);

        // Long backpressure on the first point.
        run_sweep(20, 10, 2, 1'b1);

        // Boundaries: single-cycle period, step larger than period.
        run_sweep(1, 1, 1, 1'b0);
        run_sweep(9, 12, 3, 1'b0);

        // Exact dstb timing at offset 7 with a strobe dropped in during DELAY.
        auto_stb = 1'b0; man_stb = 1'b0; res_ready_i = 1'b1;
        start_sweep(30, 7, 1, 1'b1);
        man_stb = 1'b1; step(); t0 = cyc; man_stb = 1'b0;
        dcount = 0; dcyc = -1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (dstb_o) begin dcount++; dcyc = cyc; end
        end
        check("off0_dstb_count", dcount, 1);
        check("off0_dstb_cycle", dcyc, t0 + 1);
        man_stb = 1'b1; step(); t0 = cyc; man_stb = 1'b0;
        dcount = 0; dcyc = -1;
        for (int i = 1; i <= 20; i++) begin
            man_stb = (i == 3);
            step();
            if (dstb_o) begin dcount++; dcyc = cyc; end
            if (i == 9) check("off7_result", res_valid_o && (res_offset_o == 7), 1);
        end
        man_stb = 1'b0;
        check("off7_dstb_count", dcount, 1);
        check("off7_dstb_cycle", dcyc, t0 + 8);

        // Reset in the middle of DELAY (offset now 14).
        man_stb = 1'b1; step(); man_stb = 1'b0;
        step(); step(); step();
        rst_i = 1'b1; step(); rst_i = 1'b0;
        check("mid_rst_dstb", dstb_o, 0);
        check("mid_rst_valid", res_valid_o, 0);
        check("mid_rst_offset", res_offset_o, 0);
        check("mid_rst_hits", res_hits_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_err", err_o, 0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dstb_o) dcount++;
        end
        check("mid_rst_no_dstb", dcount, 0);

        // Lock lost during DELAY of the second point.
        start_sweep(14, 7, 1, 1'b1);
        man_stb = 1'b1; step(); man_stb = 1'b0;
        repeat (5) step();
        man_stb = 1'b1; step(); man_stb = 1'b0;
        step();
        stb_valid_i = 1'b0; step(); stb_valid_i = 1'b1;
        check("abort_err", err_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_valid", res_valid_o, 0);
        dcount = 0; dn = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dstb_o) dcount++;
            if (done_o) dn++;
        end
        check("abort_no_dstb", dcount, 0);
        check("abort_no_done", dn, 0);
        check("abort_err_sticky", err_o, 1);

        // An accepted start clears the sticky error.
        start_sweep(14, 7, 1, 1'b1);
        check("start_clears_err", err_o, 0);
        check("start_clears_busy", busy_o, 1);
        res_ready_i = 1'b0;
        do_reset();

        // Rejected starts: zero step, zero period, zero N, generator unlocked.
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: start_sweep(20, 0, 4, 1'b1);
                1: start_sweep(0, 5, 4, 1'b1);
                2: start_sweep(20, 5, 0, 1'b1);
                default: start_sweep(20, 5, 4, 1'b0);
            endcase
            check("bad_start_err", err_o, 1);
            check("bad_start_busy", busy_o, 0);
            repeat (3) step();
            check("bad_start_idle", busy_o, 0);
            do_reset();
            check("bad_start_rst_err", err_o, 0);
        end

        // Randomized sweeps.
        for (int r = 0; r < 8; r++) begin
            p = $urandom_range(1, 24);
            s = $urandom_range((p / 6 > 0) ? p / 6 : 1, p + 3);
            n = $urandom_range(1, 4);
            foreach (pat[i]) pat[i] = 1'($urandom_range(0, 1));
            run_sweep(p, s, n, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
